// File: rtl/net_prot_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : net_prot_pkg
//  Brief    : Shared types and helpers for the network protocol enforcer.
//             Optional feature macro used by this slice: NET_PROT_INGR_DROP_EN
//  Revision : 1.0 - initial release
// ============================================================================
package net_prot_pkg;

  typedef enum logic [0:0] {PASS = 1'b0, DISCARD = 1'b1} egr_state_t;
  typedef enum logic [0:0] {FWD  = 1'b0, DROP    = 1'b1} ingr_state_t;

  // Widest tkeep handled by popcount (2048-bit tdata)
  localparam int KEEP_MAX_W = 256;
  localparam int POP_W      = 9;

  // Degenerate sideband widths collapse to a single bit
  function automatic int min1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // Counter must hold the worst case sum just before the limit check clears it
  function automatic int byte_cnt_width(input int max_bytes, input int beat_bytes);
    return $clog2(max_bytes + beat_bytes + 1);
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [KEEP_MAX_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/net_prot_enforcer_if.sv
`default_nettype none
// ============================================================================
//  Module   : net_prot_enforcer_if
//  Brief    : AXI-Stream bundle with master/slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface net_prot_enforcer_if #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4
);
  logic [DATA_W-1:0]   tdata;
  logic [ID_W-1:0]     tid;
  logic [DEST_W-1:0]   tdest;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tid, tdest, tkeep, tlast, tvalid, input  tready);
  modport slave  (input  tdata, tid, tdest, tkeep, tlast, tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/net_prot_ingr_timeout.sv
`default_nettype none
// ============================================================================
//  Module   : net_prot_ingr_timeout
//  Brief    : Ingress back-pressure timer, sticky timeout flag and, when
//             NET_PROT_INGR_DROP_EN is defined, the stalled-packet drop FSM.
//  Revision : 1.0 - initial release
// ============================================================================
module net_prot_ingr_timeout
  import net_prot_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 in_tvalid,
  input  logic                 in_tlast,
  input  logic                 out_tready,
  input  logic                 timeout_clear,
  output logic                 timeout_irq,
  output logic                 drop,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] r_timer;
  logic          w_timeout;
  logic          r_irq;
  logic          w_drop;

  assign w_timeout = (r_timer == TIMER_MAX);

  // Count consecutive stalled cycles; any relief (or drop mode) restarts it
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      r_timer <= '0;
    else if (w_drop || !in_tvalid || out_tready || timeout_clear)
      r_timer <= '0;
    else if (r_timer != TIMER_MAX)
      r_timer <= r_timer + 1'b1;
  end

  // Sticky timeout flag, set has priority over clear
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)           r_irq <= 1'b0;
    else if (w_timeout)     r_irq <= 1'b1;
    else if (timeout_clear) r_irq <= 1'b0;
  end

  assign timeout_irq = r_irq;

`ifdef NET_PROT_INGR_DROP_EN
  ingr_state_t          r_state;
  ingr_state_t          w_next;
  logic                 w_enter;
  logic [CNT_WIDTH-1:0] r_drop_cnt;

  // Drop FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= FWD;
    else          r_state <= w_next;
  end

  // In DROP every offered beat is accepted, so a valid tlast ends the packet
  always_comb begin
    w_next = r_state;
    case (r_state)
      FWD:     if (w_timeout) w_next = DROP;
      DROP:    if (in_tvalid && in_tlast) w_next = FWD;
      default: w_next = FWD;
    endcase
  end

  // Drop FSM outputs
  always_comb begin
    w_drop  = (r_state == DROP);
    w_enter = (r_state == FWD) && w_timeout;
  end

  // Saturating count of dropped packets, bumped on entry to DROP
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      r_drop_cnt <= '0;
    else if (w_enter && (r_drop_cnt != {CNT_WIDTH{1'b1}}))
      r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign drop_count = r_drop_cnt;
`else
  logic unused_tlast;
  assign unused_tlast = in_tlast;
  assign w_drop       = 1'b0;
  assign drop_count   = '0;
`endif

  assign drop = w_drop;

endmodule
`default_nettype wire

// File: rtl/net_prot_enforcer.sv
`default_nettype none
// ============================================================================
//  Module   : net_prot_enforcer
//  Brief    : Network protocol isolation between a user region and the shared
//             NIC. Egress enforces a per-packet byte limit with truncation;
//             ingress watches back-pressure and, with NET_PROT_INGR_DROP_EN,
//             drops stalled packets.
//  Revision : 1.0 - initial release
// ============================================================================
module net_prot_enforcer
  import net_prot_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH      = 64,
  parameter int AXIS_ID_WIDTH       = 4,
  parameter int AXIS_DEST_WIDTH     = 4,
  parameter int MAX_PACKET_BYTES    = 1522,
  parameter int INGR_TIMEOUT_CYCLES = 15,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  net_prot_enforcer_if.slave   egr_in,
  net_prot_enforcer_if.master  egr_out,
  net_prot_enforcer_if.slave   ingr_in,
  net_prot_enforcer_if.master  ingr_out,
  input  logic                 oversize_error_clear,
  output logic                 oversize_error_irq,
  input  logic                 timeout_error_clear,
  output logic                 timeout_error_irq,
  output logic [CNT_WIDTH-1:0] egr_discard_count,
  output logic [CNT_WIDTH-1:0] ingr_drop_count
);

  localparam int KEEP_W = AXIS_BUS_WIDTH / 8;
  localparam int ID_W   = min1(AXIS_ID_WIDTH);
  localparam int DEST_W = min1(AXIS_DEST_WIDTH);
  localparam int BCW    = byte_cnt_width(MAX_PACKET_BYTES, KEEP_W);
  localparam logic [BCW-1:0] LIMIT = BCW'(MAX_PACKET_BYTES);

  // ---------------------------------------------------------------- egress
  egr_state_t           r_egr_state;
  egr_state_t           w_egr_next;
  logic [BCW-1:0]       r_byte_cnt;
  logic [BCW-1:0]       w_beat_bytes;
  logic [BCW-1:0]       w_byte_sum;
  logic                 w_limit;
  logic                 w_in_tready;
  logic                 w_load;
  logic                 w_beat;
  logic                 w_oversize;

  logic [AXIS_BUS_WIDTH-1:0] r_tdata;
  logic [ID_W-1:0]           r_tid;
  logic [DEST_W-1:0]         r_tdest;
  logic [KEEP_W-1:0]         r_tkeep;
  logic                      r_tlast;
  logic                      r_tvalid;
  logic                      r_oversize_irq;
  logic [CNT_WIDTH-1:0]      r_discard_cnt;

  assign w_beat_bytes = BCW'(popcount(KEEP_MAX_W'(egr_in.tkeep)));
  assign w_byte_sum   = r_byte_cnt + w_beat_bytes;
  assign w_limit      = (w_byte_sum >= LIMIT);
  assign w_beat       = egr_in.tvalid && w_in_tready;

  // Egress FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_egr_state <= PASS;
    else          r_egr_state <= w_egr_next;
  end

  // Oversize without tlast enters DISCARD; the next tlast returns to PASS
  always_comb begin
    w_egr_next = r_egr_state;
    case (r_egr_state)
      PASS:    if (w_oversize) w_egr_next = DISCARD;
      DISCARD: if (w_beat && egr_in.tlast) w_egr_next = PASS;
      default: w_egr_next = PASS;
    endcase
  end

  // Egress FSM outputs: ready, output-register load and oversize pulse
  always_comb begin
    w_in_tready = 1'b1;
    w_load      = 1'b0;
    w_oversize  = 1'b0;
    case (r_egr_state)
      PASS: begin
        w_in_tready = egr_out.tready || !r_tvalid;
        w_load      = egr_in.tvalid && w_in_tready;
        w_oversize  = w_load && !egr_in.tlast && w_limit;
      end
      DISCARD: w_in_tready = 1'b1;
      default: w_in_tready = 1'b1;
    endcase
  end

  // Running byte count of the packet being forwarded; idle at 0 while discarding
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      r_byte_cnt <= '0;
    else if (w_load) begin
      if (egr_in.tlast || w_limit) r_byte_cnt <= '0;
      else                         r_byte_cnt <= w_byte_sum;
    end
  end

  // Single-stage output register; tlast is forced on the limit beat
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tdata  <= '0;
      r_tid    <= '0;
      r_tdest  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else if (w_load) begin
      r_tdata  <= egr_in.tdata;
      r_tid    <= egr_in.tid;
      r_tdest  <= egr_in.tdest;
      r_tkeep  <= egr_in.tkeep;
      r_tlast  <= egr_in.tlast || w_limit;
      r_tvalid <= 1'b1;
    end else if (egr_out.tready) begin
      r_tvalid <= 1'b0;
    end
  end

  // Sticky oversize flag, set has priority over clear
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                  r_oversize_irq <= 1'b0;
    else if (w_oversize)           r_oversize_irq <= 1'b1;
    else if (oversize_error_clear) r_oversize_irq <= 1'b0;
  end

  // Saturating count of truncated packets
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      r_discard_cnt <= '0;
    else if (w_oversize && (r_discard_cnt != {CNT_WIDTH{1'b1}}))
      r_discard_cnt <= r_discard_cnt + 1'b1;
  end

  assign egr_in.tready      = w_in_tready;
  assign egr_out.tdata      = r_tdata;
  assign egr_out.tid        = r_tid;
  assign egr_out.tdest      = r_tdest;
  assign egr_out.tkeep      = r_tkeep;
  assign egr_out.tlast      = r_tlast;
  assign egr_out.tvalid     = r_tvalid;
  assign oversize_error_irq = r_oversize_irq;
  assign egr_discard_count  = r_discard_cnt;

  // --------------------------------------------------------------- ingress
  logic w_drop;

  net_prot_ingr_timeout #(
    .TIMEOUT_CYCLES (INGR_TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_ingr_timeout (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .in_tvalid     (ingr_in.tvalid),
    .in_tlast      (ingr_in.tlast),
    .out_tready    (ingr_out.tready),
    .timeout_clear (timeout_error_clear),
    .timeout_irq   (timeout_error_irq),
    .drop          (w_drop),
    .drop_count    (ingr_drop_count)
  );

  // Combinational pass-through; while dropping, beats are swallowed here
  assign ingr_out.tdata  = ingr_in.tdata;
  assign ingr_out.tid    = ingr_in.tid;
  assign ingr_out.tdest  = ingr_in.tdest;
  assign ingr_out.tkeep  = ingr_in.tkeep;
  assign ingr_out.tlast  = ingr_in.tlast;
  assign ingr_out.tvalid = ingr_in.tvalid && !w_drop;
  assign ingr_in.tready  = w_drop || ingr_out.tready;

endmodule
`default_nettype wire
